// File: rtl/synth_pkg.sv
// Shared synth voice-path definitions: wave type encoding used by the selector
// and the oscillator mux, plus the selector's per-cycle action encoding.
package synth_pkg;

   localparam int NUM_WAVE_TYPES = 4;

   typedef enum logic [1:0] {
      WAVE_SINE     = 2'd0,
      WAVE_SQUARE   = 2'd1,
      WAVE_SAW      = 2'd2,
      WAVE_TRIANGLE = 2'd3
   } wave_type_t;

   typedef enum logic [1:0] {
      ACT_HOLD = 2'd0,
      ACT_LOAD = 2'd1,
      ACT_UP   = 2'd2,
      ACT_DOWN = 2'd3
   } sel_act_t;

endpackage

// File: rtl/wavetype_sel_ctrl_if.sv
// Control/status bundle between the wave-type selector and its user.
// Raw buttons are level signals; load is a single-cycle strobe qualified by load_en.
interface wavetype_sel_ctrl_if #(
   parameter int NUM_TYPES = 4
);
   localparam int TYPE_W = $clog2(NUM_TYPES);

   logic                 wave_next;
   logic                 wave_prev;
   logic                 load_en;
   logic [TYPE_W-1:0]    load_type;
   logic [NUM_TYPES-1:0] type_en;
   logic [TYPE_W-1:0]    type_switch;
   logic [NUM_TYPES-1:0] type_onehot;
   logic                 type_changed;

   modport master (
      output wave_next, wave_prev, load_en, load_type, type_en,
      input  type_switch, type_onehot, type_changed
   );

   modport slave (
      input  wave_next, wave_prev, load_en, load_type, type_en,
      output type_switch, type_onehot, type_changed
   );
endinterface

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw push-button; btn_press pulses for exactly
// one cycle on each accepted rising edge of the debounced level.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         btn_level <= 1'b0;
         level_d   <= 1'b0;
         cnt       <= '0;
      end else begin
         sync1   <= btn_raw;
         sync2   <= sync1;
         level_d <= btn_level;
         if (sync2 == btn_level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            btn_level <= sync2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign btn_press = btn_level & ~level_d;

endmodule

// File: rtl/wavetype_sel_ctrl.sv
// Wave-type selector: debounced next/prev stepping over enabled types with
// circular search, direct load, and registered binary/one-hot outputs.
module wavetype_sel_ctrl
   import synth_pkg::*;
#(
   parameter int NUM_TYPES       = NUM_WAVE_TYPES,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int RESET_TYPE      = 0
) (
   input logic               clk,
   input logic               nrst,
   wavetype_sel_ctrl_if.slave bus
);
   localparam int TYPE_W = $clog2(NUM_TYPES);
   localparam logic [TYPE_W-1:0]    RESET_IDX    = TYPE_W'(RESET_TYPE);
   localparam logic [NUM_TYPES-1:0] RESET_ONEHOT = NUM_TYPES'(1) << RESET_TYPE;

   logic     next_level;
   logic     next_press;
   logic     prev_level;
   logic     prev_press;
   logic     load_ok;
   sel_act_t act;
   logic [TYPE_W-1:0] up_type;
   logic [TYPE_W-1:0] down_type;
   logic [TYPE_W-1:0] next_type;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
      .clk       (clk),
      .nrst      (nrst),
      .btn_raw   (bus.wave_next),
      .btn_level (next_level),
      .btn_press (next_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev_db (
      .clk       (clk),
      .nrst      (nrst),
      .btn_raw   (bus.wave_prev),
      .btn_level (prev_level),
      .btn_press (prev_press)
   );

   // First enabled type after cur in the given direction, excluding cur itself;
   // returns cur when nothing else is enabled so the caller sees no change.
   function automatic logic [TYPE_W-1:0] find_step(
      input logic [TYPE_W-1:0]    cur,
      input logic [NUM_TYPES-1:0] en,
      input logic                 up
   );
      logic [TYPE_W-1:0] cand;
      logic              found;
      find_step = cur;
      found     = 1'b0;
      for (int off = 1; off < NUM_TYPES; off++) begin
         if (up) cand = TYPE_W'((int'(cur) + off) % NUM_TYPES);
         else    cand = TYPE_W'((int'(cur) + NUM_TYPES - off) % NUM_TYPES);
         if (!found && en[cand]) begin
            found     = 1'b1;
            find_step = cand;
         end
      end
   endfunction

   always_comb begin
      load_ok   = 1'b0;
      act       = ACT_HOLD;
      up_type   = find_step(bus.type_switch, bus.type_en, 1'b1);
      down_type = find_step(bus.type_switch, bus.type_en, 1'b0);
      next_type = bus.type_switch;
      if (int'(bus.load_type) < NUM_TYPES) load_ok = bus.type_en[bus.load_type];
      // An asserted load owns the cycle even when it is rejected.
      if (bus.load_en) begin
         if (load_ok) act = ACT_LOAD;
      end else if (next_press && prev_press) begin
         act = ACT_HOLD;
      end else if (next_press) begin
         act = ACT_UP;
      end else if (prev_press) begin
         act = ACT_DOWN;
      end
      case (act)
         ACT_LOAD: next_type = bus.load_type;
         ACT_UP:   next_type = up_type;
         ACT_DOWN: next_type = down_type;
         default:  next_type = bus.type_switch;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         bus.type_switch  <= RESET_IDX;
         bus.type_onehot  <= RESET_ONEHOT;
         bus.type_changed <= 1'b0;
      end else begin
         bus.type_switch  <= next_type;
         bus.type_onehot  <= NUM_TYPES'(1) << next_type;
         bus.type_changed <= (next_type != bus.type_switch);
      end
   end

endmodule

// File: tb/tb_wavetype_sel_ctrl.sv
// Self-checking bench for wavetype_sel_ctrl: directed button/load sequences with
// a change scoreboard popped on every type_changed pulse.
module tb_wavetype_sel_ctrl;
   import synth_pkg::*;

   localparam int NT = 4;
   localparam int D  = 16;
   localparam int TW = 2;

   logic clk  = 1'b0;
   logic nrst = 1'b0;

   always #5 clk = ~clk;

   wavetype_sel_ctrl_if #(.NUM_TYPES(NT)) bus ();

   wavetype_sel_ctrl #(
      .NUM_TYPES       (NT),
      .DEBOUNCE_CYCLES (D),
      .RESET_TYPE      (0)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [TW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every change pulse must match the next queued expected type.
   always @(negedge clk) begin
      logic [TW-1:0] e;
      logic [NT-1:0] oh;
      if (nrst && bus.type_changed === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse", 32'(exp_q.size()), 32'd1);
         end else begin
            e  = exp_q.pop_front();
            oh = NT'(1) << e;
            check_eq("sb_type", 32'(bus.type_switch), 32'(e));
            check_eq("sb_onehot", 32'(bus.type_onehot), 32'(oh));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic nxt, input logic prv);
      bus.wave_next = nxt;
      bus.wave_prev = prv;
      tick(D + 8);
      bus.wave_next = 1'b0;
      bus.wave_prev = 1'b0;
      tick(D + 8);
   endtask

   task automatic do_load(input logic [TW-1:0] t);
      bus.load_en   = 1'b1;
      bus.load_type = t;
      tick(1);
      bus.load_en   = 1'b0;
   endtask

   task automatic drain(input string tag);
      check_eq(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bus.wave_next = 1'b0;
      bus.wave_prev = 1'b0;
      bus.load_en   = 1'b0;
      bus.load_type = '0;
      bus.type_en   = 4'b1111;

      // Reset values while held in reset
      tick(3);
      check_eq("rst_type", 32'(bus.type_switch), 32'd0);
      check_eq("rst_onehot", 32'(bus.type_onehot), 32'h1);
      check_eq("rst_changed", 32'(bus.type_changed), 32'd0);
      nrst = 1'b1;
      tick(5);

      // Move away from reset value, then reset in the middle of a debounce count
      exp_q.push_back(2'd2);
      do_load(2'd2);
      tick(2);
      bus.wave_next = 1'b1;
      tick(10);
      #2 nrst = 1'b0;
      #1;
      check_eq("midrst_type", 32'(bus.type_switch), 32'd0);
      check_eq("midrst_onehot", 32'(bus.type_onehot), 32'h1);
      check_eq("midrst_changed", 32'(bus.type_changed), 32'd0);
      bus.wave_next = 1'b0;
      tick(2);
      nrst = 1'b1;
      tick(D + 10);
      check_eq("post_rst_hold", 32'(bus.type_switch), 32'd0);
      drain("drain_reset");

      // Clean press: change lands DEBOUNCE_CYCLES+3 edges after the drive
      bus.wave_next = 1'b1;
      exp_q.push_back(2'd1);
      tick(D + 2);
      check_eq("pre_latency", 32'(bus.type_switch), 32'd0);
      tick(1);
      check_eq("latency_type", 32'(bus.type_switch), 32'd1);
      check_eq("latency_pulse", 32'(bus.type_changed), 32'd1);
      tick(1);
      check_eq("pulse_width", 32'(bus.type_changed), 32'd0);
      tick(100);
      check_eq("no_repeat", 32'(bus.type_switch), 32'd1);
      bus.wave_next = 1'b0;
      tick(D + 10);
      check_eq("release_no_step", 32'(bus.type_switch), 32'd1);
      drain("drain_clean");

      // Bounce: toggle every 5 cycles for 60 cycles, then settle high
      for (int i = 0; i < 12; i++) begin
         bus.wave_next = ~bus.wave_next;
         tick(5);
      end
      check_eq("bounce_ignored", 32'(bus.type_switch), 32'd1);
      bus.wave_next = 1'b1;
      exp_q.push_back(2'd2);
      tick(D + 10);
      bus.wave_next = 1'b0;
      tick(D + 10);
      check_eq("bounce_one_step", 32'(bus.type_switch), 32'd2);
      drain("drain_bounce");

      // Wrap and skip with type 2 masked
      bus.type_en = 4'b1011;
      exp_q.push_back(2'd1);
      do_load(2'd1);
      check_eq("load_1", 32'(bus.type_switch), 32'd1);
      exp_q.push_back(2'd3);
      press(1'b1, 1'b0);
      check_eq("skip_up", 32'(bus.type_switch), 32'd3);
      exp_q.push_back(2'd0);
      press(1'b1, 1'b0);
      check_eq("wrap_up", 32'(bus.type_switch), 32'd0);
      exp_q.push_back(2'd3);
      press(1'b0, 1'b1);
      check_eq("wrap_down", 32'(bus.type_switch), 32'd3);
      drain("drain_wrap");

      // Lone enabled type: presses hold
      bus.type_en = 4'b0100;
      exp_q.push_back(2'd2);
      do_load(2'd2);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      check_eq("lone_hold", 32'(bus.type_switch), 32'd2);
      drain("drain_lone");

      // Load on the same cycle as an accepted press: load wins, single pulse
      bus.type_en   = 4'b1111;
      bus.wave_next = 1'b1;
      tick(D + 2);
      bus.load_en   = 1'b1;
      bus.load_type = 2'd3;
      exp_q.push_back(2'd3);
      tick(1);
      bus.load_en   = 1'b0;
      check_eq("load_beats_press", 32'(bus.type_switch), 32'd3);
      tick(1);
      check_eq("load_single_pulse", 32'(bus.type_changed), 32'd0);
      tick(D + 4);
      bus.wave_next = 1'b0;
      tick(D + 10);
      check_eq("load_press_final", 32'(bus.type_switch), 32'd3);
      drain("drain_load_press");

      // Masked load ignored, load of current value gives no pulse
      bus.type_en = 4'b1011;
      do_load(2'd2);
      check_eq("masked_load", 32'(bus.type_switch), 32'd3);
      do_load(2'd3);
      tick(2);
      check_eq("same_load", 32'(bus.type_switch), 32'd3);
      drain("drain_masked");

      // Current type masked off: holds, next step searches from it
      bus.type_en = 4'b0011;
      tick(3);
      check_eq("masked_cur_hold", 32'(bus.type_switch), 32'd3);
      exp_q.push_back(2'd0);
      press(1'b1, 1'b0);
      check_eq("masked_cur_step", 32'(bus.type_switch), 32'd0);
      drain("drain_masked_cur");

      // Simultaneous next+prev presses cancel
      bus.type_en = 4'b1111;
      press(1'b1, 1'b1);
      check_eq("cancel", 32'(bus.type_switch), 32'd0);
      check_eq("cancel_onehot", 32'(bus.type_onehot), 32'h1);
      drain("drain_cancel");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
